// File: rtl/for_in_channel.sv
// Loads words into a small FIFO, then on run streams a preamble followed by
// (remaining-count, value) pairs per buffered word, tagging each output word with a wrapping area index.
module for_in_channel #(
  parameter int WIDTH      = 12,
  parameter int NIN        = 3,
  parameter int NOUT       = 9,
  parameter int NPRE       = 3,
  parameter int EMIT_COUNT = 1,
  localparam int IW        = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             run,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [IW-1:0]    out_index,
  output logic             busy,
  output logic             finished,
  output logic [2:0]       state_dbg
);

  localparam int PW  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int FW  = $clog2(NIN + 1);
  localparam int PCW = (NPRE > 1) ? $clog2(NPRE) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SIZE = 3'd2,
    CNT  = 3'd3,
    VAL  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [NIN];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [FW-1:0]    fill, remaining;
  logic [PCW-1:0]   pre_idx;
  logic             rst_done;
  logic             idle_like, push, pop, hs, start;

  // Both channels use valid/ready: a word moves on a rising edge where valid and ready
  // are both high; once valid is raised, it and the data stay put until that edge.
  assign idle_like = (state == IDLE) || (state == DONE);
  assign in_ready  = rst_done && idle_like && (fill < FW'(NIN));
  assign push      = in_valid && in_ready;
  assign out_valid = (state == PRE) || (state == CNT) || (state == VAL);
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (state == VAL);
  assign start     = idle_like && run;
  assign busy      = !idle_like;
  assign finished  = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    out_data = '0;
    case (state)
      IDLE, DONE: if (run) state_nx = (NPRE > 0) ? PRE : SIZE;
      PRE: begin
        out_data = WIDTH'(pre_idx) + WIDTH'(1);
        if (out_ready && pre_idx == PCW'((NPRE > 0) ? NPRE - 1 : 0)) state_nx = SIZE;
      end
      SIZE: begin
        if (fill == '0)           state_nx = DONE;
        else if (EMIT_COUNT != 0) state_nx = CNT;
        else                      state_nx = VAL;
      end
      CNT: begin
        out_data = WIDTH'(remaining);
        if (out_ready) state_nx = VAL;
      end
      VAL: begin
        out_data = mem[rd_ptr];
        if (out_ready) state_nx = SIZE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rst_done  <= 1'b0;
      pre_idx   <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_index <= '0;
    end else begin
      rst_done <= 1'b1;
      state    <= state_nx;
      if (start)                           pre_idx <= '0;
      else if (state == PRE && out_ready)  pre_idx <= pre_idx + PCW'(1);
      if (state == SIZE) remaining <= fill;
      if (push) wr_ptr <= (wr_ptr == PW'(NIN - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(NIN - 1)) ? '0 : rd_ptr + PW'(1);
      // Loads only happen outside the loop and pops only inside it, so never both.
      if (push)     fill <= fill + FW'(1);
      else if (pop) fill <= fill - FW'(1);
      if (hs) out_index <= (out_index == IW'(NOUT - 1)) ? '0 : out_index + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_for_in_channel.sv
// Bench for for_in_channel: vector table, randomized loads against a sequence model,
// and hand sequences for reset mid-stream and the NPRE=0 / values-only variant.
module tb_for_in_channel;
  localparam int W = 12;
  localparam int NOUT = 9;
  localparam int NPRE = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         in_valid = 1'b0, in_ready, run = 1'b0;
  logic [W-1:0] in_data = '0, out_data;
  logic         out_valid, out_ready = 1'b0, busy, finished;
  logic [3:0]   out_index;
  logic [2:0]   state_dbg;

  logic         in_valid0 = 1'b0, in_ready0, run0 = 1'b0;
  logic [W-1:0] in_data0 = '0, out_data0;
  logic         out_valid0, out_ready0 = 1'b0, busy0, finished0;
  logic [3:0]   out_index0;
  logic [2:0]   state_dbg0;

  for_in_channel dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .run(run), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_index(out_index), .busy(busy), .finished(finished), .state_dbg(state_dbg)
  );

  for_in_channel #(.EMIT_COUNT(0), .NPRE(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .run(run0), .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
    .out_index(out_index0), .busy(busy0), .finished(finished0), .state_dbg(state_dbg0)
  );

  int           compares = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  int           exp_idx = 0;
  bit           mon_en = 0;
  int           hs_count = 0;
  bit           stall_prev = 0;
  logic [W-1:0] stall_data = '0;
  logic [3:0]   stall_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the head of exp_q at the model's index.
  always @(negedge clock) begin
    if (mon_en) begin
      if (stall_prev) begin
        compares++;
        if (!out_valid || out_data !== stall_data || out_index !== stall_idx) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%0d i=%0d, expected v=1 d=%0d i=%0d",
                   out_valid, out_data, out_index, stall_data, stall_idx);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_index;
      if (out_valid && out_ready) begin
        hs_count++;
        compares++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_word: got unexpected d=%0d i=%0d, expected no word", out_data, out_index);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e || out_index !== exp_idx[3:0]) begin
            fails++;
            $display("FAIL out_word: got d=%0d i=%0d, expected d=%0d i=%0d", out_data, out_index, e, exp_idx);
          end
        end
        exp_idx = (exp_idx + 1) % NOUT;
      end
    end
  end

  // Reference sequence: preamble 1..NPRE, then for each word its remaining count and the word.
  task automatic model_fill(input int n, input logic [W-1:0] w[4]);
    for (int i = 0; i < NPRE; i++) exp_q.push_back(W'(i + 1));
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(W'(n - j));
      exp_q.push_back(w[j]);
    end
  endtask

  task automatic push_word(input logic [W-1:0] v, output logic acc);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clock);
    acc = in_ready;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: ready high plus a run pulse in VAL, 3: random ready
  task automatic drain(input int mode, input int budget);
    int cyc;
    bit pulsed;
    cyc = 0;
    pulsed = 0;
    stall_prev = 0;
    mon_en = 1;
    run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
    while (!finished && cyc < budget) begin
      case (mode)
        0, 2:    out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && !pulsed && state_dbg == 3'd4) begin
        run = 1'b1;
        pulsed = 1;
      end
      @(posedge clock);
      #1 run = 1'b0;
      cyc++;
    end
    mon_en = 0;
    check("drain_in_budget", 32'(cyc < budget), 1);
    check("exp_left", exp_q.size(), 0);
    check("finished", finished, 1);
    check("end_out_index", out_index, exp_idx);
    if (mode == 2) check("run_pulsed_in_val", pulsed, 1);
  endtask

  typedef struct {
    int           n;
    logic [W-1:0] w[4];
    int           mode;
    int           len;
    logic [W-1:0] seq[9];
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic         acc;
    logic [W-1:0] w[4];
    logic [W-1:0] got[$];
    int           n;

    vecs[0] = '{3, '{33, 22, 11, 0}, 0, 9, '{1, 2, 3, 3, 33, 2, 22, 1, 11}};
    vecs[1] = '{3, '{33, 22, 11, 0}, 1, 9, '{1, 2, 3, 3, 33, 2, 22, 1, 11}};
    vecs[2] = '{0, '{0, 0, 0, 0},    0, 3, '{1, 2, 3, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{1, '{5, 0, 0, 0},    3, 5, '{1, 2, 3, 1, 5, 0, 0, 0, 0}};
    vecs[4] = '{3, '{33, 22, 11, 0}, 2, 9, '{1, 2, 3, 3, 33, 2, 22, 1, 11}};

    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check("in_ready_after_rst", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        push_word(vecs[i].w[j], acc);
        check("vec_load_accept", acc, 1);
      end
      for (int j = 0; j < vecs[i].len; j++) exp_q.push_back(vecs[i].seq[j]);
      drain(vecs[i].mode, 200);
    end

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) w[j] = W'($urandom);
      for (int j = 0; j < n; j++) begin
        push_word(w[j], acc);
        check("rand_load_accept", acc, 1);
      end
      model_fill(n, w);
      drain(3, 300);
    end

    w = '{1, 2, 3, 4};
    for (int j = 0; j < 4; j++) begin
      push_word(w[j], acc);
      check("overfill_accept", acc, (j < 3) ? 1 : 0);
    end
    check("overfill_in_ready", in_ready, 0);
    model_fill(3, w);
    drain(0, 200);

    w = '{33, 22, 11, 0};
    for (int j = 0; j < 3; j++) push_word(w[j], acc);
    model_fill(3, w);
    hs_count = 0;
    stall_prev = 0;
    mon_en = 1;
    out_ready = 1'b1;
    run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
    for (int c = 0; c < 60 && hs_count < 5; c++) begin
      @(posedge clock);
      #1;
    end
    check("mid_hs_count", hs_count, 5);
    mon_en = 0;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_index", out_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_finished", finished, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    exp_idx = 0;
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    push_word(12'd7, acc);
    check("reload_accept", acc, 1);
    exp_q = '{1, 2, 3, 1, 7};
    drain(0, 100);

    for (int j = 0; j < 2; j++) begin
      in_valid0 = 1'b1;
      in_data0  = W'(5 + j);
      @(negedge clock);
      check("v0_in_ready", in_ready0, 1);
      @(posedge clock);
      #1 in_valid0 = 1'b0;
    end
    out_ready0 = 1'b1;
    run0 = 1'b1;
    @(posedge clock);
    #1 run0 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (out_valid0) got.push_back(out_data0);
      if (finished0) break;
    end
    check("v0_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("v0_word0", got[0], 5);
      check("v0_word1", got[1], 6);
    end
    check("v0_finished", finished0, 1);
    check("v0_out_index", out_index0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
